lamp_fpu_div_norm_round: RTL

Post-processing stage directly downstream of the Goldschmidt fractional divider in the bfloat16 FPU. It captures sign, operand exponents and special-case class when a division is launched, waits for the divider's raw Q2.14 quotient, then normalizes it, rounds it round-to-nearest-even, handles overflow and underflow, and packs a bfloat16 result. The packed result is held behind a valid/ready handshake toward the FPU result port.

---
 rtl/lamp_fpu_div_norm_round_pkg.sv | 43 ++++
 rtl/lamp_fpu_div_norm_round_rnd_ne.sv | 26 ++
 rtl/lamp_fpu_div_norm_round.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/lamp_fpu_div_norm_round_pkg.sv
// lampFPU_pkg: bfloat16 widths, bias, special-class and FSM enums shared by
// the divider post-processing stage.
package lampFPU_pkg;

    localparam int LAMP_FLOAT_E_DW   = 8;
    localparam int LAMP_FLOAT_F_DW   = 7;
    localparam int LAMP_FLOAT_E_BIAS = 127;
    localparam int LAMP_FLOAT_DW     = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

    localparam logic [LAMP_FLOAT_DW-1:0]   LAMP_BF16_QNAN    = 16'h7FC0;
    localparam logic [LAMP_FLOAT_E_DW-1:0] LAMP_BF16_INF_EXP = 8'hFF;

    typedef enum logic [1:0] {
        DIV_SPEC_NONE = 2'b00,
        DIV_SPEC_ZERO = 2'b01,
        DIV_SPEC_INF  = 2'b10,
        DIV_SPEC_NAN  = 2'b11
    } lampDivSpecial_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        NORM = 2'd2,
        HOLD = 2'd3
    } ssDivNR_t;

    // Packed result for an operand pair that bypasses the divider.
    // NaN is always the positive quiet NaN; the sign is dropped.
    function automatic logic [LAMP_FLOAT_DW-1:0] lamp_div_special_res(
        input lampDivSpecial_t cls,
        input logic            sign
    );
        logic [LAMP_FLOAT_DW-1:0] res;
        case (cls)
            DIV_SPEC_ZERO: res = {sign, {(LAMP_FLOAT_DW-1){1'b0}}};
            DIV_SPEC_INF:  res = {sign, LAMP_BF16_INF_EXP, {LAMP_FLOAT_F_DW{1'b0}}};
            DIV_SPEC_NAN:  res = LAMP_BF16_QNAN;
            default:       res = {LAMP_FLOAT_DW{1'b0}};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lamp_fpu_div_norm_round_rnd_ne.sv
// lamp_fpu_rnd_ne: round-to-nearest-even of an 8-bit normalized mantissa
// (hidden bit included). A carry out wraps the mantissa to 8'h80 so the
// caller only has to bump the exponent.
module lamp_fpu_rnd_ne
    import lampFPU_pkg::*;
(
    input  logic [LAMP_FLOAT_F_DW:0] mant_i,
    input  logic                     guard_i,
    input  logic                     sticky_i,
    output logic [LAMP_FLOAT_F_DW:0] mant_o,
    output logic                     carry_o
);

    logic                       inc;
    logic [LAMP_FLOAT_F_DW+1:0] sum;

    // Ties go to the even mantissa: increment only when above half, or at
    // exactly half with an odd lsb.
    always_comb begin
        inc     = guard_i & (sticky_i | mant_i[0]);
        sum     = {1'b0, mant_i} + {{(LAMP_FLOAT_F_DW+1){1'b0}}, inc};
        carry_o = sum[LAMP_FLOAT_F_DW+1];
        mant_o  = carry_o ? {1'b1, {LAMP_FLOAT_F_DW{1'b0}}} : sum[LAMP_FLOAT_F_DW:0];
    end

endmodule

// File: rtl/lamp_fpu_div_norm_round.sv
// lamp_fpu_div_norm_round: normalizes, RNE-rounds, range-checks and packs
// the Goldschmidt divider's Q2.14 quotient into bfloat16, holding the result
// behind a valid/ready handshake.
// Optional: define LAMP_FPU_DIV_FLAGS_EN to add flags_o
// {invalid, overflow, underflow, inexact}.
//
// state | meaning
// IDLE  | waiting for doDiv_i; res_o keeps its last value
// WAIT  | operands captured, waiting for the divider quotient
// NORM  | normalized mantissa registered; round, range check, pack
// HOLD  | res_o valid, waiting for ready_i
module lamp_fpu_div_norm_round
    import lampFPU_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       doDiv_i,
    input  logic                       sign_i,
    input  logic [LAMP_FLOAT_E_DW-1:0] expA_i,
    input  logic [LAMP_FLOAT_E_DW-1:0] expB_i,
    input  logic [1:0]                 special_i,
    input  logic [15:0]                quot_i,
    input  logic                       quotValid_i,
    input  logic                       ready_i,
    output logic [LAMP_FLOAT_DW-1:0]   res_o,
    output logic                       valid_o,
    output logic                       busy_o
`ifdef LAMP_FPU_DIV_FLAGS_EN
    ,
    output logic [3:0]                 flags_o
`endif
);

    localparam int EXP_W = LAMP_FLOAT_E_DW + 2;

    ssDivNR_t state_q, state_d;
    lampDivSpecial_t special_cls;

    logic                       sign_q;
    logic [LAMP_FLOAT_E_DW-1:0] exp_a_q, exp_b_q;
    logic signed [EXP_W-1:0]    exp_q;
    logic [LAMP_FLOAT_F_DW:0]   mant_q;
    logic                       guard_q, sticky_q;
    logic [LAMP_FLOAT_DW-1:0]   res_q;

    logic signed [EXP_W-1:0]    exp_diff, exp_n, exp_rnd;
    logic [LAMP_FLOAT_F_DW:0]   mant_n, mant_rnd;
    logic                       guard_n, sticky_n, carry;
    logic                       ovf, unf;
    logic [LAMP_FLOAT_DW-1:0]   res_norm;
    logic                       unused_bits;

`ifdef LAMP_FPU_DIV_FLAGS_EN
    logic [3:0] flags_q;
`endif

    assign special_cls = lampDivSpecial_t'(special_i);
    // quot_i[15] is never set for a quotient in (0.5, 2).
    assign unused_bits = ^{quot_i[15], mant_rnd[LAMP_FLOAT_F_DW]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (doDiv_i) state_d = (special_cls == DIV_SPEC_NONE) ? WAIT : HOLD;
            WAIT: if (quotValid_i) state_d = NORM;
            NORM: state_d = HOLD;
            HOLD: if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Exponent difference and one-bit normalization of the raw quotient.
    always_comb begin
        exp_diff = $signed({2'b00, exp_a_q}) - $signed({2'b00, exp_b_q})
                   + EXP_W'(LAMP_FLOAT_E_BIAS);
        if (quot_i[14]) begin
            mant_n   = quot_i[14:7];
            guard_n  = quot_i[6];
            sticky_n = |quot_i[5:0];
            exp_n    = exp_diff;
        end else begin
            mant_n   = quot_i[13:6];
            guard_n  = quot_i[5];
            sticky_n = |quot_i[4:0];
            exp_n    = exp_diff - 10'sd1;
        end
    end

    lamp_fpu_rnd_ne u_rnd (
        .mant_i   (mant_q),
        .guard_i  (guard_q),
        .sticky_i (sticky_q),
        .mant_o   (mant_rnd),
        .carry_o  (carry)
    );

    // Range check on the post-rounding exponent and final packing.
    always_comb begin
        exp_rnd = carry ? exp_q + 10'sd1 : exp_q;
        ovf     = (exp_rnd >= 10'sd255);
        unf     = (exp_rnd <= 10'sd0);
        if (ovf)
            res_norm = {sign_q, LAMP_BF16_INF_EXP, {LAMP_FLOAT_F_DW{1'b0}}};
        else if (unf)
            res_norm = {sign_q, {(LAMP_FLOAT_DW-1){1'b0}}};
        else
            res_norm = {sign_q, exp_rnd[LAMP_FLOAT_E_DW-1:0], mant_rnd[LAMP_FLOAT_F_DW-1:0]};
    end

    // Operand capture, normalized-quotient register and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q   <= 1'b0;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            exp_q    <= '0;
            mant_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            res_q    <= '0;
`ifdef LAMP_FPU_DIV_FLAGS_EN
            flags_q  <= 4'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (doDiv_i) begin
                        sign_q  <= sign_i;
                        exp_a_q <= expA_i;
                        exp_b_q <= expB_i;
                        if (special_cls != DIV_SPEC_NONE) begin
                            res_q <= lamp_div_special_res(special_cls, sign_i);
`ifdef LAMP_FPU_DIV_FLAGS_EN
                            flags_q <= {special_cls == DIV_SPEC_NAN, 3'b000};
`endif
                        end
                    end
                end
                WAIT: begin
                    if (quotValid_i) begin
                        exp_q    <= exp_n;
                        mant_q   <= mant_n;
                        guard_q  <= guard_n;
                        sticky_q <= sticky_n;
                    end
                end
                NORM: begin
                    res_q <= res_norm;
`ifdef LAMP_FPU_DIV_FLAGS_EN
                    flags_q <= {1'b0, ovf, unf & ~ovf, guard_q | sticky_q | ovf | unf};
`endif
                end
                default: ;
            endcase
        end
    end

    assign res_o   = res_q;
    assign valid_o = (state_q == HOLD);
    assign busy_o  = (state_q != IDLE);
`ifdef LAMP_FPU_DIV_FLAGS_EN
    assign flags_o = flags_q;
`endif

endmodule
